// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the memory port arbiter slice.
//   state_t      : arbiter FSM states, encoding visible on st_dbg
//   owner_t      : current grant holder, encoding visible on owner_dbg
//   RD_LAT_MIN/MAX and rd_lat_legal() : legal range of the RAM read latency

package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // The latency counter is two bits wide, so only 1..3 can be represented.
    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2
// Combinational two-way round-robin pick.
//   req[1:0] in  : request vector, bit 0 = CPU, bit 1 = DMA
//   last     in  : 1 when the DMA held the most recent grant
//   gnt[1:0] out : one-hot grant (all zero when nothing is requested)

module mem_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the side that was not served
    // last time gets the grant.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between the CPU and the DMA/loader.
// One access at a time, round-robin on contention, req/ack handshake per side.
//   clk, reset_n                : clock, asynchronous active-low reset
//   cpu_* / dma_*               : requester ports (req, we, be, addr, wdata in;
//                                 rdata, ack, err out)
//   mem_en/we/be/addr/wdata     : RAM control, all zero when mem_en is low
//   mem_rdata                   : RAM read data, valid RD_LAT cycles after mem_en
//   owner_dbg, st_dbg           : current grant holder and FSM state

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MEM_WORDS = 1024
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [DATA_W/8-1:0] cpu_be,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_ack,
    output logic                cpu_err,

    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [DATA_W/8-1:0] dma_be,
    input  logic [ADDR_W-1:0]   dma_addr,
    input  logic [DATA_W-1:0]   dma_wdata,
    output logic [DATA_W-1:0]   dma_rdata,
    output logic                dma_ack,
    output logic                dma_err,

    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic [1:0]          owner_dbg,
    output logic [1:0]          st_dbg
);

    localparam int BE_W   = DATA_W / 8;
    localparam int WIDX_W = ADDR_W - 2;

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT must be in 1..3");
    end

    state_t              state;
    state_t              next_state;
    owner_t              owner_q;
    owner_t              last_grant;
    logic                we_q;
    logic [BE_W-1:0]     be_q;
    logic [WIDX_W-1:0]   widx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                err_q;
    logic [1:0]          cnt_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   dma_rdata_q;
    logic [1:0]          gnt;
    logic                in_range;

    // Byte-offset bits do not take part in word addressing.
    logic                unused_addr_lsbs;
    assign unused_addr_lsbs = ^{cpu_addr[1:0], dma_addr[1:0]};

    mem_arb_rr2 u_rr2 (
        .req  ({dma_req, cpu_req}),
        .last (last_grant == OWN_DMA),
        .gnt  (gnt)
    );

    assign in_range = {2'b00, widx_q} < ADDR_W'(MEM_WORDS);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Out-of-range and write accesses skip the wait state;
    // reads sit in S_WAIT until the counter reaches 1.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (gnt != 2'b00) next_state = S_ISSUE;
            S_ISSUE: next_state = (!in_range || we_q) ? S_ACK : S_WAIT;
            S_WAIT:  if (cnt_q == 2'd1) next_state = S_ACK;
            S_ACK:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Request latch, latency counter, error flag, round-robin history and the
    // per-port read data registers. Everything the RAM sees comes from the
    // latch, so requesters may change their fields after the grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q     <= OWN_NONE;
            last_grant  <= OWN_DMA;
            we_q        <= 1'b0;
            be_q        <= '0;
            widx_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= 2'd0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt[0]) begin
                        owner_q <= OWN_CPU;
                        we_q    <= cpu_we;
                        be_q    <= cpu_be;
                        widx_q  <= cpu_addr[ADDR_W-1:2];
                        wdata_q <= cpu_wdata;
                        err_q   <= 1'b0;
                    end else if (gnt[1]) begin
                        owner_q <= OWN_DMA;
                        we_q    <= dma_we;
                        be_q    <= dma_be;
                        widx_q  <= dma_addr[ADDR_W-1:2];
                        wdata_q <= dma_wdata;
                        err_q   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    err_q <= !in_range;
                    if (in_range && !we_q) begin
                        cnt_q <= 2'(RD_LAT);
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        if (owner_q == OWN_CPU) begin
                            cpu_rdata_q <= mem_rdata;
                        end else if (owner_q == OWN_DMA) begin
                            dma_rdata_q <= mem_rdata;
                        end
                    end
                end
                S_ACK: begin
                    last_grant <= owner_q;
                    owner_q    <= OWN_NONE;
                end
                default: begin
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    // Output logic. The RAM is only driven in S_ISSUE for an in-range word;
    // the ack pulse and error flag go only to the current owner.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ack   = 1'b0;
        cpu_err   = 1'b0;
        dma_ack   = 1'b0;
        dma_err   = 1'b0;
        if (state == S_ISSUE && in_range) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_be    = be_q;
            mem_addr  = widx_q;
            mem_wdata = wdata_q;
        end
        if (state == S_ACK) begin
            if (owner_q == OWN_CPU) begin
                cpu_ack = 1'b1;
                cpu_err = err_q;
            end else if (owner_q == OWN_DMA) begin
                dma_ack = 1'b1;
                dma_err = err_q;
            end
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign owner_dbg = owner_q;
    assign st_dbg    = state;

endmodule
